led_fade_driver: RTL and testbench
==================================

// Module: led_fade_driver
// PURPOSE
//  Downstream consumer of the SoC's 8-bit LED PIO export. Turns each on/off bit from software into
//  a smooth brightness ramp (fade-in/fade-out) and drives the board LEDs via per-LED PWM.
//  Sits between the SoC instance and the LED pins in the top level, on the same clock (clk_clk).
// PARAMETERS
//  N_LEDS       8      number of LED channels
//  PWM_BITS     8      PWM counter and brightness level width; MAX = 2**PWM_BITS-1
//  STEP_CYCLES  50000  clocks per brightness step (1 ms at 50 MHz); >=2
// PORTS
//  clk_clk        in   1       system clock, single clock domain
//  reset_reset_n  in   1       asynchronous, active-low reset
//  led_in         in   N_LEDS  target on/off per LED, from SoC LED export
//  led_out        out  N_LEDS  registered PWM drive to LED pins
//  busy           out  1       high while any channel is ramping (RISE or FALL)
// BEHAVIOUR
//  Reset (async assert): led_out=0, busy=0, all levels=0, all channels OFF, prescaler=0, pwm_cnt=0.
//  led_in registered once (tgt); FSM acts on tgt, so 1 cycle input latency.
//  Prescaler: counts 0..STEP_CYCLES-1, wraps; tick=1 for the one cycle it equals STEP_CYCLES-1.
//  pwm_cnt: free-running PWM_BITS counter, +1 every clock, wraps MAX->0.
//  Per-channel FSM (states OFF, RISE, ON, FALL), level is PWM_BITS unsigned:
//   OFF : level=0; tgt=1 -> RISE.
//   RISE: on tick level+=1; level becomes MAX -> ON; tgt=0 -> FALL.
//   ON  : level=MAX; tgt=0 -> FALL.
//   FALL: on tick level-=1; level becomes 0 -> OFF; tgt=1 -> RISE.
//  Direction reversal mid-ramp continues from current level; no jump, no wrap (saturate 0/MAX).
//  Simultaneous tick and tgt change: state transition wins, level unchanged that cycle.
//  led_out[i] (registered, 1 cycle after duty/pwm_cnt): OFF -> 0; ON -> constant 1;
//   RISE/FALL -> (duty_i > pwm_cnt), giving duty_i high cycles per 2**PWM_BITS window.
//  busy = OR over channels of (state==RISE || state==FALL), registered.
//  Full fade 0->MAX takes MAX*STEP_CYCLES clocks (+ prescaler phase, <= STEP_CYCLES-1).
// CONFIGURATION
//  LED_GAMMA_EN defined: duty = (level*level) >> PWM_BITS (perceptual curve, 2*PWM_BITS product).
//  LED_GAMMA_EN undefined: duty = level (linear). ON/OFF forcing identical in both builds.
// STRUCTURE
//  Package led_fade_pkg: state enum {OFF,RISE,ON,FALL} (2 bits), default parameter constants.
//  Sub-module led_fade_channel (one per LED, generate loop): FSM, level, duty, PWM compare.
//  Top holds input register, prescaler, pwm_cnt, busy OR-reduction.
// TESTING (bench uses PWM_BITS=4, STEP_CYCLES=4, MAX=15)
//  1 Assert reset_reset_n=0 mid-anything -> led_out=0x00, busy=0 immediately, before any clock edge.
//  2 led_in 0x00->0x01 -> busy=1 in 2 clocks; level[0] reaches 15 after 15 ticks (~60 clocks);
//    then led_out[0] constant 1, busy=0; led_out[7:1] stay 0 throughout.
//  3 led_in=0x01 for 5 ticks then 0x00 -> level[0] 5,4,...,0 one per tick, no jump; OFF, led_out[0]=0.
//  4 Linear build, freeze prescaler via force at level 8 -> led_out[0] high exactly 8 of every
//    16 clocks.
//  5 led_in toggled on the same cycle as tick -> state flips, level unchanged that cycle, then
//    moves in the new direction on the next tick.
//  6 LED_GAMMA_EN build, level 8 -> duty 4 (4 high of 16 clocks); level 15 in ON -> constant 1.

Source files
------------

// File: rtl/led_fade_pkg.sv
// Shared state encoding and default sizing for the LED fade driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package led_fade_pkg;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RISE = 2'd1,
        ON   = 2'd2,
        FALL = 2'd3
    } fade_state_t;

    localparam int DEF_N_LEDS      = 8;
    localparam int DEF_PWM_BITS    = 8;
    localparam int DEF_STEP_CYCLES = 50000;

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: fade FSM, brightness level, optional gamma (LED_GAMMA_EN) and PWM compare.
// Latency: tgt to state 1 clock; led registered 1 clock after state/level/pwm_cnt.
// Backpressure: none; free-running, tick-paced ramp.
module led_fade_channel
    import led_fade_pkg::*;
#(
    parameter int PWM_BITS = DEF_PWM_BITS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tgt,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led,
    output logic                ramp_nxt
);

    localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
    localparam logic [PWM_BITS-1:0] LVL_ONE = {{(PWM_BITS-1){1'b0}}, 1'b1};

    fade_state_t         state_q, state_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic                led_q, led_d;
    logic [PWM_BITS-1:0] duty;

    // A target change outranks a tick: the level holds for that cycle.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        case (state_q)
            OFF: begin
                level_d = '0;
                if (tgt) state_d = RISE;
            end
            RISE: begin
                if (!tgt) begin
                    state_d = FALL;
                end else if (tick) begin
                    if (level_q >= LVL_MAX - LVL_ONE) begin
                        level_d = LVL_MAX;
                        state_d = ON;
                    end else begin
                        level_d = level_q + LVL_ONE;
                    end
                end
            end
            ON: begin
                level_d = LVL_MAX;
                if (!tgt) state_d = FALL;
            end
            FALL: begin
                if (tgt) begin
                    state_d = RISE;
                end else if (tick) begin
                    if (level_q <= LVL_ONE) begin
                        level_d = '0;
                        state_d = OFF;
                    end else begin
                        level_d = level_q - LVL_ONE;
                    end
                end
            end
            default: state_d = OFF;
        endcase
    end

`ifdef LED_GAMMA_EN
    logic [2*PWM_BITS-1:0] level_sq;
    assign level_sq = level_q * level_q;
    assign duty     = level_sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign duty = level_q;
`endif

    always_comb begin
        led_d = 1'b0;
        case (state_q)
            OFF:     led_d = 1'b0;
            ON:      led_d = 1'b1;
            default: led_d = (duty > pwm_cnt);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OFF;
            level_q <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            led_q   <= led_d;
        end
    end

    assign led      = led_q;
    assign ramp_nxt = (state_d == RISE) || (state_d == FALL);

endmodule

// File: rtl/led_fade_driver.sv
// Fades each LED toward its software on/off target with per-LED PWM; gamma curve under LED_GAMMA_EN.
// Latency: led_in to channel FSM 1 clock; led_out 1 clock after state; busy aligned with state.
// Backpressure: none; led_in is sampled every clock.
module led_fade_driver
    import led_fade_pkg::*;
#(
    parameter int N_LEDS      = DEF_N_LEDS,
    parameter int PWM_BITS    = DEF_PWM_BITS,
    parameter int STEP_CYCLES = DEF_STEP_CYCLES
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [N_LEDS-1:0] led_in,
    output logic [N_LEDS-1:0] led_out,
    output logic              busy
);

    localparam int PRESC_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_CYCLES - 1);

    logic [N_LEDS-1:0]   tgt_q, tgt_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                busy_q, busy_d;
    logic                tick;
    logic [N_LEDS-1:0]   led_ch;
    logic [N_LEDS-1:0]   ramp_nxt;

    assign tick = (presc_q == PRESC_LAST);

    always_comb begin
        tgt_d     = led_in;
        presc_d   = tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        busy_d    = |ramp_nxt;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tgt_q     <= '0;
            presc_q   <= '0;
            pwm_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            tgt_q     <= tgt_d;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            busy_q    <= busy_d;
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
        led_fade_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk      (clk_clk),
            .rst_n    (reset_reset_n),
            .tgt      (tgt_q[i]),
            .tick     (tick),
            .pwm_cnt  (pwm_cnt_q),
            .led      (led_ch[i]),
            .ramp_nxt (ramp_nxt[i])
        );
    end

    assign led_out = led_ch;
    assign busy    = busy_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Scoreboard bench for led_fade_driver with PWM_BITS=4, STEP_CYCLES=4 (MAX=15).
// Expectations are queued per cycle index after reset release; a monitor pops them at negedge.
module tb_led_fade_driver;

    localparam int K_OUT = 0;
    localparam int K_LVL = 1;
    localparam int K_PWM = 2;
`ifdef LED_GAMMA_EN
    localparam int DUTY8_HIGHS = 4;
`else
    localparam int DUTY8_HIGHS = 8;
`endif

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] led;
        logic       bsy;
        logic [7:0] mask;
        int         val;
        string      name;
    } exp_t;

    logic       clk_clk = 1'b0;
    logic       reset_reset_n = 1'b0;
    logic [7:0] led_in = 8'h00;
    logic [7:0] led_out;
    logic       busy;

    int    cyc_cnt = 0;
    int    base = 0;
    int    checks = 0;
    int    failures = 0;
    logic [15:0] hist = '0;
    exp_t  sb[$];
    exp_t  cur;
    event  chk_now;

    led_fade_driver #(
        .N_LEDS      (8),
        .PWM_BITS    (4),
        .STEP_CYCLES (4)
    ) dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .led_in        (led_in),
        .led_out       (led_out),
        .busy          (busy)
    );

    always #5 clk_clk = ~clk_clk;

    always @(posedge clk_clk) cyc_cnt <= cyc_cnt + 1;
    always @(negedge clk_clk) hist <= {hist[14:0], led_out[0]};

    task automatic push(input int k, input int kind, input logic [7:0] l, input logic b,
                        input logic [7:0] m, input int v, input string n);
        exp_t e;
        e.cyc = base + k; e.kind = kind; e.led = l; e.bsy = b; e.mask = m; e.val = v; e.name = n;
        sb.push_back(e);
    endtask

    task automatic exp_out(input int k, input logic [7:0] l, input logic b, input logic [7:0] m,
                           input string n);
        push(k, K_OUT, l, b, m, 0, n);
    endtask

    task automatic exp_lvl(input int k, input int v, input string n);
        push(k, K_LVL, 8'h00, 1'b0, 8'h00, v, n);
    endtask

    task automatic check_item(input exp_t e);
        int act;
        checks++;
        case (e.kind)
            K_OUT: begin
                if (((led_out & e.mask) !== e.led) || (busy !== e.bsy)) begin
                    failures++;
                    $display("FAIL %s: got led_out=%02h busy=%b, want led_out=%02h busy=%b (mask %02h)",
                             e.name, led_out, busy, e.led, e.bsy, e.mask);
                end
            end
            K_LVL: begin
                act = int'(dut.g_ch[0].u_ch.level_q);
                if (act != e.val) begin
                    failures++;
                    $display("FAIL %s: got level0=%0d, want %0d", e.name, act, e.val);
                end
            end
            default: begin
                act = $countones(hist);
                if (act != e.val) begin
                    failures++;
                    $display("FAIL %s: got %0d high of 16, want %0d", e.name, act, e.val);
                end
            end
        endcase
    endtask

    initial begin
        forever begin
            @(negedge clk_clk or chk_now);
            while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
                cur = sb.pop_front();
                check_item(cur);
            end
        end
    end

    task automatic do_reset(input logic [7:0] li);
        reset_reset_n = 1'b0;
        led_in = 8'h00;
        repeat (2) @(posedge clk_clk);
        #1;
        led_in = li;
        reset_reset_n = 1'b1;
        base = cyc_cnt;
    endtask

    task automatic wait_e(input int k);
        while (cyc_cnt < base + k) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic async_reset_check(input string n);
        #2;
        reset_reset_n = 1'b0;
        #1;
        base = cyc_cnt;
        exp_out(0, 8'h00, 1'b0, 8'hFF, n);
        exp_lvl(0, 0, {n, "_lvl"});
        -> chk_now;
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Full fade-in to ON; level k lands on edge 4k, RISE entered at edge 2.
        do_reset(8'h01);
        exp_out(1, 8'h00, 1'b0, 8'hFF, "rst_state");
        exp_lvl(1, 0, "rst_level");
        exp_out(2, 8'h00, 1'b1, 8'hFF, "busy_2clk");
        exp_out(30, 8'h00, 1'b1, 8'hFE, "others_off_mid");
        exp_lvl(30, 7, "rise_mid_level");
        exp_lvl(59, 14, "rise_pre_max");
        exp_out(59, 8'h00, 1'b1, 8'hFE, "busy_pre_max");
        exp_lvl(60, 15, "rise_at_max");
        exp_out(60, 8'h00, 1'b0, 8'hFE, "busy_drop_on");
        exp_out(61, 8'h01, 1'b0, 8'hFF, "on_led");
        exp_out(70, 8'h01, 1'b0, 8'hFF, "on_led_hold");
        push(77, K_PWM, 8'h00, 1'b0, 8'h00, 16, "on_constant");
        wait_e(80);
        async_reset_check("async_rst_on");

        // Fade-in to level 5, then fade-out from 5 without a jump.
        do_reset(8'h01);
        exp_lvl(20, 5, "five_ticks");
        exp_lvl(22, 5, "fall_no_jump");
        exp_out(22, 8'h00, 1'b1, 8'hFE, "fall_busy");
        exp_lvl(24, 4, "fall_4");
        exp_lvl(28, 3, "fall_3");
        exp_lvl(36, 1, "fall_1");
        exp_out(39, 8'h00, 1'b1, 8'hFE, "fall_busy_end");
        exp_lvl(40, 0, "fall_0");
        exp_out(40, 8'h00, 1'b0, 8'hFE, "off_busy");
        exp_out(41, 8'h00, 1'b0, 8'hFF, "off_led");
        wait_e(20);
        led_in = 8'h00;
        wait_e(45);

        // Target drops in the same cycle as a tick: reverse without moving the level.
        do_reset(8'h01);
        exp_lvl(12, 3, "rev_pre");
        exp_lvl(15, 3, "rev_tgt_seen");
        exp_lvl(16, 3, "rev_tick_held");
        exp_out(16, 8'h00, 1'b1, 8'hFE, "rev_busy");
        exp_lvl(19, 3, "rev_hold");
        exp_lvl(20, 2, "rev_next_tick");
        wait_e(14);
        led_in = 8'h00;
        wait_e(22);
        async_reset_check("async_rst_ramp");

        // Frozen prescaler at level 8: count PWM high cycles over one window.
        do_reset(8'h01);
        exp_lvl(32, 8, "freeze_level");
        push(55, K_PWM, 8'h00, 1'b0, 8'h00, DUTY8_HIGHS, "pwm_duty8");
        exp_lvl(55, 8, "frozen_level");
        exp_out(55, 8'h00, 1'b1, 8'hFE, "frozen_busy");
        wait_e(32);
        force dut.presc_q = '0;
        wait_e(56);
        release dut.presc_q;

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk_clk);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d expectations never reached, want 0", sb.size());
            failures += sb.size();
            checks += sb.size();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
